mem_responder: RTL

//  Memory-side responder for the two snooping cache controllers. Each cache port issues IDEL/RD/WT requests.
//  The block arbitrates the two ports round-robin and serves one transaction at a time against a word array.
//  It answers with a 1-cycle read_en_k (data on data_o_k) or write_done_k pulse after a fixed latency.

---
 rtl/mem_responder_pkg.sv | 29 ++
 rtl/mem_arbiter.sv | 38 +++
 rtl/mem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared widths, request codes and FSM states for the memory responder.
// Optional feature macro: MEM_ERR_CHECK_EN (see isRequest).
package mem_responder_pkg;

    localparam int unsigned IOSTATEWIDTH = 2;
    localparam int unsigned ADDRWIDTH    = 16;
    localparam int unsigned WORDWIDTH    = 16;

    localparam logic [IOSTATEWIDTH-1:0] IDEL  = 2'b00;
    localparam logic [IOSTATEWIDTH-1:0] RD    = 2'b01;
    localparam logic [IOSTATEWIDTH-1:0] WT    = 2'b10;
    localparam logic [IOSTATEWIDTH-1:0] RWBAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Code 11 only counts as a request when error checking is built in.
    function automatic logic isRequest(input logic [IOSTATEWIDTH-1:0] rw);
`ifdef MEM_ERR_CHECK_EN
        return rw != IDEL;
`else
        return (rw == RD) || (rw == WT);
`endif
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with a one-cycle turnaround mask on the
// port that was just served, so a late-dropped request cannot re-trigger.
module mem_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    input  logic respCycle,
    output logic gntValid,
    output logic gntPort
);

    logic lastGrantQ;
    logic maskQ;
    logic eff0;
    logic eff1;

    always_comb begin
        eff0     = req0 && !(maskQ && !lastGrantQ);
        eff1     = req1 && !(maskQ && lastGrantQ);
        gntValid = eff0 || eff1;
        gntPort  = (eff0 && eff1) ? ~lastGrantQ : eff1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrantQ <= 1'b1;
            maskQ      <= 1'b0;
        end else begin
            maskQ <= respCycle;
            if (accept) begin
                lastGrantQ <= gntPort;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates two cache ports and serves one fixed-latency
// transaction at a time. Define MEM_ERR_CHECK_EN for out-of-range/code-11 error flagging.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] rw_0,
    input  logic [IOSTATEWIDTH-1:0] rw_1,
    input  logic [ADDRWIDTH-1:0]    addr_0,
    input  logic [ADDRWIDTH-1:0]    addr_1,
    input  logic [WORDWIDTH-1:0]    data_0,
    input  logic [WORDWIDTH-1:0]    data_1,
    output logic [WORDWIDTH-1:0]    data_o_0,
    output logic [WORDWIDTH-1:0]    data_o_1,
    output logic                    read_en_0,
    output logic                    read_en_1,
    output logic                    write_done_0,
    output logic                    write_done_1,
    output logic                    err_o
);

    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                  stateQ, stateD;
    logic [CNTW-1:0]         cntQ, cntD;
    logic                    portQ;
    logic [IOSTATEWIDTH-1:0] rwQ;
    logic [IDXW-1:0]         idxQ;
    logic [WORDWIDTH-1:0]    dataQ;
    logic [WORDWIDTH-1:0]    mem [DEPTH];

    logic                    gntValid, gntPort, accept, respCycle, loadRead, memOk, writeCode;
    logic [IOSTATEWIDTH-1:0] selRw;
    logic [ADDRWIDTH-1:0]    selAddr;

    mem_arbiter u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .req0     (isRequest(rw_0)),
        .req1     (isRequest(rw_1)),
        .accept   (accept),
        .respCycle(respCycle),
        .gntValid (gntValid),
        .gntPort  (gntPort)
    );

    assign accept    = (stateQ == S_IDLE) && gntValid;
    assign respCycle = (stateQ == S_RESP);
    assign loadRead  = (stateQ == S_WAIT) && (cntQ == '0);
    assign selRw     = gntPort ? rw_1 : rw_0;
    assign selAddr   = gntPort ? addr_1 : addr_0;

`ifdef MEM_ERR_CHECK_EN
    logic badQ;
    logic errQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            badQ <= 1'b0;
            errQ <= 1'b0;
        end else begin
            if (accept) begin
                badQ <= (32'(selAddr) >= DEPTH) || (selRw == RWBAD);
            end
            if (loadRead && badQ) begin
                errQ <= 1'b1;
            end
        end
    end

    assign memOk     = !badQ;
    assign err_o     = errQ;
    assign writeCode = (rwQ == WT) || (rwQ == RWBAD);
`else
    logic unusedAddr;
    assign unusedAddr = ^{addr_0, addr_1};
    assign memOk      = 1'b1;
    assign err_o      = 1'b0;
    assign writeCode  = (rwQ == WT);
`endif

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            S_IDLE: begin
                if (accept) begin
                    stateD = S_WAIT;
                    cntD   = CNTW'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cntQ == '0) begin
                    stateD = S_RESP;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            S_RESP:  stateD = S_IDLE;
            default: stateD = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= S_IDLE;
            cntQ     <= '0;
            portQ    <= 1'b0;
            rwQ      <= IDEL;
            idxQ     <= '0;
            dataQ    <= '0;
            data_o_0 <= '0;
            data_o_1 <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                portQ <= gntPort;
                rwQ   <= selRw;
                idxQ  <= selAddr[IDXW-1:0];
                dataQ <= gntPort ? data_1 : data_0;
            end
            if (loadRead && (rwQ == RD)) begin
                if (portQ) begin
                    data_o_1 <= memOk ? mem[idxQ] : '0;
                end else begin
                    data_o_0 <= memOk ? mem[idxQ] : '0;
                end
            end
        end
    end

    // Array has no reset; a reset while a write is pending simply drops it.
    always_ff @(posedge clk) begin
        if (!reset && respCycle && (rwQ == WT) && memOk) begin
            mem[idxQ] <= dataQ;
        end
    end

    assign read_en_0    = respCycle && !portQ && (rwQ == RD);
    assign read_en_1    = respCycle && portQ && (rwQ == RD);
    assign write_done_0 = respCycle && !portQ && writeCode;
    assign write_done_1 = respCycle && portQ && writeCode;

endmodule
